// File: rtl/axis_pkt_gen_pkg.sv
// Shared types for the AXI4-Stream test packet generator.
package axis_pkt_gen_pkg;

    // Run-level phases: waiting for start, streaming beats, idling between packets.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream master that emits runs of incrementing-pattern test packets.
// Every stream output is a register; tvalid is never a function of tready.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = 2,
    parameter int DEST_W = 4,
    parameter int USER_W = 8,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [CNT_W-1:0]      cfg_count,
    input  logic [GAP_W-1:0]      cfg_gap,
    input  logic [DATA_W-1:0]     cfg_seed,
    input  logic [ID_W-1:0]       cfg_id,
    input  logic [DEST_W-1:0]     cfg_dest,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tstrb,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [ID_W-1:0]       m_axis_tid,
    output logic [DEST_W-1:0]     m_axis_tdest,
    output logic [USER_W-1:0]     m_axis_tuser
);

    state_t state, state_next;

    logic [LEN_W-1:0]  len_r, len_d, beat_cnt, beat_d, beat_inc, len_m1, eff_len;
    logic [CNT_W-1:0]  count_r, count_d, pkt_cnt_d;
    logic [GAP_W-1:0]  gap_r, gap_d, gap_cnt, gap_cnt_d;
    logic              stop_pend, stop_pend_d, stop_now;
    logic              hs, last_hs, final_pkt, start_ok;
    logic              tvalid_d, tlast_d, done_d, busy_d;
    logic [DATA_W-1:0] tdata_d;
    logic [ID_W-1:0]   tid_d;
    logic [DEST_W-1:0] tdest_d;
    logic [USER_W-1:0] tuser_d;

    assign m_axis_tstrb = '1;
    assign m_axis_tkeep = '1;

    assign eff_len   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign len_m1    = len_r - 1'b1;
    assign beat_inc  = beat_cnt + 1'b1;
    assign hs        = m_axis_tvalid & m_axis_tready;
    assign last_hs   = hs & m_axis_tlast;
    assign stop_now  = stop_pend | stop;
    assign start_ok  = start & ~stop;
    assign final_pkt = (count_r != '0) && ((pkt_cnt + CNT_W'(1)) == count_r);

    // State register; reset returns to idle so tvalid drops without waiting for a clock.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Phase transitions: packets only end on a last-beat handshake; a pending stop ends the run there or in a gap.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_ok) state_next = ST_SEND;
            ST_SEND: begin
                if (last_hs) begin
                    if (final_pkt || stop_now) state_next = ST_IDLE;
                    else if (gap_r != '0)      state_next = ST_GAP;
                    else                       state_next = ST_SEND;
                end
            end
            ST_GAP: begin
                if (stop_now)                 state_next = ST_IDLE;
                else if (gap_cnt == GAP_W'(1)) state_next = ST_SEND;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters; the first SEND cycle after start only raises tvalid.
    always_comb begin
        len_d       = len_r;
        count_d     = count_r;
        gap_d       = gap_r;
        gap_cnt_d   = gap_cnt;
        beat_d      = beat_cnt;
        pkt_cnt_d   = pkt_cnt;
        stop_pend_d = stop_pend;
        tvalid_d    = m_axis_tvalid;
        tlast_d     = m_axis_tlast;
        tdata_d     = m_axis_tdata;
        tid_d       = m_axis_tid;
        tdest_d     = m_axis_tdest;
        tuser_d     = m_axis_tuser;
        done_d      = 1'b0;
        busy_d      = (state_next != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d       = eff_len;
                    count_d     = cfg_count;
                    gap_d       = cfg_gap;
                    tid_d       = cfg_id;
                    tdest_d     = cfg_dest;
                    tdata_d     = cfg_seed;
                    beat_d      = '0;
                    tlast_d     = (eff_len == LEN_W'(1));
                    tuser_d     = '0;
                    pkt_cnt_d   = '0;
                    stop_pend_d = 1'b0;
                    tvalid_d    = 1'b0;
                end
            end
            ST_SEND: begin
                stop_pend_d = stop_now;
                if (!m_axis_tvalid) begin
                    tvalid_d = 1'b1;
                end else if (hs) begin
                    tdata_d = m_axis_tdata + 1'b1;
                    if (m_axis_tlast) begin
                        beat_d    = '0;
                        tlast_d   = (len_r == LEN_W'(1));
                        tuser_d   = m_axis_tuser + 1'b1;
                        if (pkt_cnt != '1) pkt_cnt_d = pkt_cnt + 1'b1;
                        gap_cnt_d = gap_r;
                        tvalid_d  = (state_next == ST_SEND);
                        done_d    = (state_next == ST_IDLE);
                    end else begin
                        beat_d  = beat_inc;
                        tlast_d = (beat_inc == len_m1);
                    end
                end
            end
            ST_GAP: begin
                stop_pend_d = stop_now;
                gap_cnt_d   = gap_cnt - 1'b1;
                tvalid_d    = (state_next == ST_SEND);
                done_d      = (state_next == ST_IDLE);
            end
            default: begin
                tvalid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_r         <= LEN_W'(1);
            count_r       <= '0;
            gap_r         <= '0;
            gap_cnt       <= '0;
            beat_cnt      <= '0;
            pkt_cnt       <= '0;
            stop_pend     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            len_r         <= len_d;
            count_r       <= count_d;
            gap_r         <= gap_d;
            gap_cnt       <= gap_cnt_d;
            beat_cnt      <= beat_d;
            pkt_cnt       <= pkt_cnt_d;
            stop_pend     <= stop_pend_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tid    <= tid_d;
            m_axis_tdest  <= tdest_d;
            m_axis_tuser  <= tuser_d;
            done          <= done_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: scoreboard queue filled from a run-level model,
// drained by an independent stream monitor.
module tb_axis_pkt_gen;

    localparam int DATA_W = 32;
    localparam int ID_W   = 2;
    localparam int DEST_W = 4;
    localparam int USER_W = 8;
    localparam int LEN_W  = 16;
    localparam int CNT_W  = 16;
    localparam int GAP_W  = 8;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic                start, stop;
    logic [LEN_W-1:0]    cfg_len;
    logic [CNT_W-1:0]    cfg_count;
    logic [GAP_W-1:0]    cfg_gap;
    logic [DATA_W-1:0]   cfg_seed;
    logic [ID_W-1:0]     cfg_id;
    logic [DEST_W-1:0]   cfg_dest;
    logic                busy, done;
    logic [CNT_W-1:0]    pkt_cnt;
    logic                m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DATA_W-1:0]   m_axis_tdata;
    logic [DATA_W/8-1:0] m_axis_tstrb, m_axis_tkeep;
    logic [ID_W-1:0]     m_axis_tid;
    logic [DEST_W-1:0]   m_axis_tdest;
    logic [USER_W-1:0]   m_axis_tuser;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [USER_W-1:0] user;
    } beat_t;

    beat_t             exp_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                hs_count = 0;
    int                exp_gap  = 0;
    bit                rnd_ready = 1'b0;
    logic [ID_W-1:0]   exp_id   = '0;
    logic [DEST_W-1:0] exp_dest = '0;

    axis_pkt_gen #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W), .USER_W(USER_W),
        .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
        .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
        .cfg_seed(cfg_seed), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
        .m_axis_tuser(m_axis_tuser)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: beat k of a run carries seed+k; packet p has tuser p and ends every len beats.
    task automatic pushRun(input int len, input int npkts, input logic [DATA_W-1:0] seed);
        int l;
        beat_t e;
        l = (len == 0) ? 1 : len;
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < l; b++) begin
                e.data = seed + DATA_W'(p * l + b);
                e.last = (b == l - 1);
                e.user = USER_W'(p);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic setCfg(input int len, input int count, input int gap,
                          input logic [DATA_W-1:0] seed, input int id, input int dest);
        cfg_len   = LEN_W'(len);
        cfg_count = CNT_W'(count);
        cfg_gap   = GAP_W'(gap);
        cfg_seed  = seed;
        cfg_id    = ID_W'(id);
        cfg_dest  = DEST_W'(dest);
        exp_id    = ID_W'(id);
        exp_dest  = DEST_W'(dest);
        exp_gap   = gap;
    endtask

    task automatic scrambleCfg();
        cfg_len   = LEN_W'($urandom_range(1, 9));
        cfg_count = CNT_W'($urandom_range(1, 9));
        cfg_gap   = GAP_W'($urandom_range(0, 5));
        cfg_seed  = $urandom;
        cfg_id    = ID_W'($urandom);
        cfg_dest  = DEST_W'($urandom);
    endtask

    task automatic pulse(input bit do_start, input bit do_stop);
        @(posedge aclk); #1;
        start = do_start;
        stop  = do_stop;
        @(posedge aclk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitDone(input int exp_pkts);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge aclk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 64'(seen), 64'(1));
        if (seen) begin
            checkOutput("busy_at_done", 64'(busy), 64'(0));
            checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts));
            checkOutput("beats_left", 64'(exp_q.size()), 64'(0));
            @(negedge aclk);
            checkOutput("done_width", 64'(done), 64'(0));
            checkOutput("tvalid_after_run", 64'(m_axis_tvalid), 64'(0));
        end
    endtask

    task automatic applyStimulus(input int len, input int count, input int gap,
                                 input logic [DATA_W-1:0] seed, input bit inject_start);
        setCfg(len, count, gap, seed, $urandom_range(0, 3), $urandom_range(0, 15));
        pushRun(len, count, seed);
        pulse(1'b1, 1'b0);
        scrambleCfg();
        @(negedge aclk);
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        checkOutput("tvalid_latency_low", 64'(m_axis_tvalid), 64'(0));
        @(negedge aclk);
        checkOutput("tvalid_latency_high", 64'(m_axis_tvalid), 64'(1));
        if (inject_start) pulse(1'b1, 1'b0);
        waitDone(count);
    endtask

    // tready source: always ready, or a 50% coin flip per cycle.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and inter-packet gaps.
    initial begin
        bit                     stall;
        bit                     gap_pending;
        int                     gap_low;
        logic [DATA_W+USER_W:0] saved;
        beat_t                  e;
        stall       = 1'b0;
        gap_pending = 1'b0;
        gap_low     = 0;
        saved       = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall       = 1'b0;
                gap_pending = 1'b0;
                continue;
            end
            if (gap_pending) begin
                if (!m_axis_tvalid) gap_low++;
                else begin
                    checkOutput("gap_cycles", 64'(gap_low), 64'(exp_gap));
                    gap_pending = 1'b0;
                end
            end
            if (stall) begin
                checkOutput("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
                checkOutput("stall_payload", 64'({m_axis_tlast, m_axis_tuser, m_axis_tdata}), 64'(saved));
            end
            stall = m_axis_tvalid && !m_axis_tready;
            if (stall) saved = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL extra_beat: got tdata 0x%0h, expected no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tdata", 64'(m_axis_tdata), 64'(e.data));
                    checkOutput("tlast", 64'(m_axis_tlast), 64'(e.last));
                    checkOutput("tuser", 64'(m_axis_tuser), 64'(e.user));
                    checkOutput("tid", 64'(m_axis_tid), 64'(exp_id));
                    checkOutput("tdest", 64'(m_axis_tdest), 64'(exp_dest));
                    if (e.last && exp_q.size() > 0) begin
                        gap_pending = 1'b1;
                        gap_low     = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        bit hit;
        aresetn = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        setCfg(1, 1, 0, '0, 0, 0);
        #2;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("rst_tlast", 64'(m_axis_tlast), 64'(0));
        checkOutput("rst_tdata", 64'(m_axis_tdata), 64'(0));
        checkOutput("rst_tuser", 64'(m_axis_tuser), 64'(0));
        checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        checkOutput("rst_tkeep", 64'(m_axis_tkeep), 64'(4'hF));
        checkOutput("rst_tstrb", 64'(m_axis_tstrb), 64'(4'hF));
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        $display("[TB] single packet, len 4, seed 0x10");
        applyStimulus(4, 1, 0, 32'h10, 1'b0);

        $display("[TB] two packets with a 2-cycle gap");
        applyStimulus(3, 2, 2, 32'h100, 1'b0);

        $display("[TB] random tready, len 5, count 3, start while busy");
        rnd_ready = 1'b1;
        applyStimulus(5, 3, 0, 32'hA000, 1'b1);
        rnd_ready = 1'b0;

        $display("[TB] zero length and data wrap");
        applyStimulus(0, 2, 0, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            rnd_ready = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 3), $urandom, 1'b0);
        end
        rnd_ready = 1'b0;

        $display("[TB] continuous mode, stop mid packet 2");
        setCfg(4, 0, 1, 32'h5000, 2, 7);
        pushRun(4, 2, 32'h5000);
        base = hs_count;
        pulse(1'b1, 1'b0);
        hit = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge aclk);
            if (hs_count - base >= 5) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("reached_packet2", 64'(hit), 64'(1));
        pulse(1'b0, 1'b1);
        waitDone(2);

        $display("[TB] continuous mode, stop during gap");
        setCfg(2, 0, 5, 32'h7700, 1, 3);
        pushRun(2, 1, 32'h7700);
        base = hs_count;
        pulse(1'b1, 1'b0);
        hit = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge aclk);
            if (hs_count - base >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("reached_gap", 64'(hit), 64'(1));
        pulse(1'b0, 1'b1);
        waitDone(1);

        $display("[TB] start together with stop starts nothing");
        setCfg(3, 1, 0, 32'h1234, 0, 0);
        pulse(1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            @(negedge aclk);
            checkOutput("startstop_busy", 64'(busy), 64'(0));
            checkOutput("startstop_tvalid", 64'(m_axis_tvalid), 64'(0));
        end

        $display("[TB] reset during beat 2 of an 8-beat packet");
        setCfg(8, 1, 0, 32'hBEEF_0000, 3, 9);
        pushRun(8, 1, 32'hBEEF_0000);
        pulse(1'b1, 1'b0);
        hit = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tdata == 32'hBEEF_0002) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("reached_beat2", 64'(hit), 64'(1));
        #2 aresetn = 1'b0;
        #1;
        checkOutput("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("midrst_tlast", 64'(m_axis_tlast), 64'(0));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_tdata", 64'(m_axis_tdata), 64'(0));
        exp_q.delete();
        @(posedge aclk); #1 aresetn = 1'b1;
        applyStimulus(3, 1, 0, 32'hBEEF_0000, 1'b0);

        repeat (3) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
